// File: rtl/test_sweep_ctrl.sv
// test_sweep_ctrl
//   Automated self-test sweep sequencer for the transceiver test-mux fabric.
//   Walks the enabled test modes in ascending order. Each mode gets a settle
//   window of SETTLE_CYC cycles and then a measure window of max(dwell,1)
//   cycles. During the measure window the observation selects rotate
//   0,1,2,3,... and the observed bits are folded into a signature.
//
//   Optional feature: define TEST_SWEEP_MISR_EN to build the 16-bit MISR
//   (polynomial 0x1021) behind outSignature. Without it, outSignature is
//   tied to zero and no MISR logic is built.
//
// Parameters
//   DWELL_W     width of the per-mode measure-length input (>= 2)
//   SETTLE_CYC  settle cycles after each path-select change (>= 1)
//
// Ports
//   inClock       system clock, rising edge
//   inReset       asynchronous active-low reset
//   inStart       sweep request, honoured only while idle
//   inAbort       terminates a sweep in progress
//   inModeMask    bit i enables mode i (path select = i)
//   inDwell       measure cycles per mode, 0 behaves as 1
//   inObs         {flag observation bit, data observation bit}
//   outSel1       3-bit path select for the 1:8 / 8:1 test muxes
//   outSel9       select for the 4-bit observation muxes
//   outSel15      select for the 1-bit observation muxes
//   outBusy       high from SETTLE through DONE
//   outModeValid  high on every MEASURE cycle
//   outDone       one-cycle pulse on normal completion
//   outAborted    one-cycle pulse when a sweep is aborted
//   outErrNoMode  one-cycle pulse when a start arrives with an empty mask
//   outSignature  observation signature
module test_sweep_ctrl #(
  parameter int DWELL_W    = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic               inClock,
  input  logic               inReset,
  input  logic               inStart,
  input  logic               inAbort,
  input  logic [7:0]         inModeMask,
  input  logic [DWELL_W-1:0] inDwell,
  input  logic [1:0]         inObs,
  output logic [2:0]         outSel1,
  output logic [1:0]         outSel9,
  output logic [1:0]         outSel15,
  output logic               outBusy,
  output logic               outModeValid,
  output logic               outDone,
  output logic               outAborted,
  output logic               outErrNoMode,
  output logic [15:0]        outSignature
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYC - 1);

  // Lowest set mask bit whose index is >= lo. Result is {found, index}.
  // lo is 4 bits wide so that "above mode 7" (lo = 8) finds nothing
  // instead of wrapping back to mode 0.
  function automatic logic [3:0] find_set_from(input logic [7:0] mask,
                                               input logic [3:0] lo);
    logic [3:0] res;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= lo)) begin
        res = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

  // Control state
  state_t              r_state;
  logic [7:0]          r_mask;
  logic [DWELL_W-1:0]  r_dwell;
  logic [2:0]          r_mode;
  logic [SCNT_W-1:0]   r_scnt;
  logic [DWELL_W-1:0]  r_mcnt;

  // Registered outputs
  logic [2:0]          r_sel1;
  logic [1:0]          r_sel9;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;
  logic                r_err;

  // Next-state values
  state_t              w_state_nxt;
  logic [7:0]          w_mask_nxt;
  logic [DWELL_W-1:0]  w_dwell_nxt;
  logic [2:0]          w_mode_nxt;
  logic [SCNT_W-1:0]   w_scnt_nxt;
  logic [DWELL_W-1:0]  w_mcnt_nxt;
  logic                w_abort_evt;
  logic                w_err_evt;
  logic                w_sig_clr;
  logic                w_sig_upd;

  logic [3:0]          w_first;
  logic [3:0]          w_next;
  logic [DWELL_W-1:0]  w_mlast;
  logic                w_meas_last;

  assign w_first     = find_set_from(inModeMask, 4'd0);
  assign w_next      = find_set_from(r_mask, {1'b0, r_mode} + 4'd1);
  // A latched dwell of 0 still gives one measure cycle.
  assign w_mlast     = (r_dwell == '0) ? '0 : (r_dwell - 1'b1);
  assign w_meas_last = (r_mcnt == w_mlast);

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_dwell_nxt = r_dwell;
    w_mode_nxt  = r_mode;
    w_scnt_nxt  = r_scnt;
    w_mcnt_nxt  = r_mcnt;
    w_abort_evt = 1'b0;
    w_err_evt   = 1'b0;
    w_sig_clr   = 1'b0;
    w_sig_upd   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // inAbort is deliberately not looked at here: a simultaneous
        // start wins, and abort alone in idle does nothing.
        if (inStart) begin
          if (inModeMask != 8'h00) begin
            w_mask_nxt  = inModeMask;
            w_dwell_nxt = inDwell;
            w_mode_nxt  = w_first[2:0];
            w_scnt_nxt  = '0;
            w_mcnt_nxt  = '0;
            w_sig_clr   = 1'b1;
            w_state_nxt = ST_SETTLE;
          end else begin
            w_err_evt = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (inAbort) begin
          w_abort_evt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_scnt == SCNT_LAST) begin
          w_mcnt_nxt  = '0;
          w_state_nxt = ST_MEASURE;
        end else begin
          w_scnt_nxt = r_scnt + 1'b1;
        end
      end

      ST_MEASURE: begin
        // Every measure cycle folds its observation in, including one
        // cut short by an abort; the signature then holds.
        w_sig_upd = 1'b1;
        if (inAbort) begin
          w_abort_evt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_meas_last) begin
          if (w_next[3]) begin
            w_mode_nxt  = w_next[2:0];
            w_scnt_nxt  = '0;
            w_mcnt_nxt  = '0;
            w_state_nxt = ST_SETTLE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_mcnt_nxt = r_mcnt + 1'b1;
        end
      end

      ST_DONE: begin
        if (inAbort) begin
          w_abort_evt = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_dwell <= '0;
      r_mode  <= '0;
      r_scnt  <= '0;
      r_mcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_dwell <= w_dwell_nxt;
      r_mode  <= w_mode_nxt;
      r_scnt  <= w_scnt_nxt;
      r_mcnt  <= w_mcnt_nxt;
    end
  end

  // Outputs are registered from the next-state values so that each one
  // lines up with the state it describes, without any input-to-output
  // combinational path.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      r_sel1    <= '0;
      r_sel9    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sel1    <= ((w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_MEASURE)) ?
                   w_mode_nxt : 3'd0;
      r_sel9    <= (w_state_nxt == ST_MEASURE) ? w_mcnt_nxt[1:0] : 2'd0;
      r_valid   <= (w_state_nxt == ST_MEASURE);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= (w_state_nxt == ST_DONE);
      r_aborted <= w_abort_evt;
      r_err     <= w_err_evt;
    end
  end

  assign outSel1      = r_sel1;
  assign outSel9      = r_sel9;
  assign outSel15     = r_sel9;
  assign outBusy      = r_busy;
  assign outModeValid = r_valid;
  assign outDone      = r_done;
  assign outAborted   = r_aborted;
  assign outErrNoMode = r_err;

`ifdef TEST_SWEEP_MISR_EN
  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [1:0]  obs);
    return {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {14'b0, obs};
  endfunction

  logic [15:0] r_sig;

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      r_sig <= '0;
    end else if (w_sig_clr) begin
      r_sig <= '0;
    end else if (w_sig_upd) begin
      r_sig <= misr_step(r_sig, inObs);
    end
  end

  assign outSignature = r_sig;
`else
  logic w_unused_sig;
  assign w_unused_sig = ^{inObs, w_sig_clr, w_sig_upd};
  assign outSignature = 16'h0000;
`endif

endmodule

// File: tb/tb_test_sweep_ctrl.sv
// Testbench for test_sweep_ctrl: directed vector table, hand-written corner
// sequences and randomized stimulus, all checked against a timeline model.
module tb_test_sweep_ctrl;

  localparam int DWELL_W    = 8;
  localparam int SETTLE_CYC = 2;

`ifdef TEST_SWEEP_MISR_EN
  localparam logic [15:0] EXP_SIG_D0   = 16'h0001;
  localparam logic [15:0] EXP_SIG_D2   = 16'h0003;
`else
  localparam logic [15:0] EXP_SIG_D0   = 16'h0000;
  localparam logic [15:0] EXP_SIG_D2   = 16'h0000;
`endif

  logic               inClock;
  logic               inReset;
  logic               inStart;
  logic               inAbort;
  logic [7:0]         inModeMask;
  logic [DWELL_W-1:0] inDwell;
  logic [1:0]         inObs;
  logic [2:0]         outSel1;
  logic [1:0]         outSel9;
  logic [1:0]         outSel15;
  logic               outBusy;
  logic               outModeValid;
  logic               outDone;
  logic               outAborted;
  logic               outErrNoMode;
  logic [15:0]        outSignature;

  test_sweep_ctrl #(
    .DWELL_W    (DWELL_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .inClock      (inClock),
    .inReset      (inReset),
    .inStart      (inStart),
    .inAbort      (inAbort),
    .inModeMask   (inModeMask),
    .inDwell      (inDwell),
    .inObs        (inObs),
    .outSel1      (outSel1),
    .outSel9      (outSel9),
    .outSel15     (outSel15),
    .outBusy      (outBusy),
    .outModeValid (outModeValid),
    .outDone      (outDone),
    .outAborted   (outAborted),
    .outErrNoMode (outErrNoMode),
    .outSignature (outSignature)
  );

  initial inClock = 1'b0;
  always #5 inClock = ~inClock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a sweep is expanded at start into its per-cycle
  // timeline of expected outputs.
  typedef struct {
    logic [2:0] sel1;
    logic [1:0] sel;
    logic       valid;
    logic       busy;
    logic       done;
  } rec_t;

  localparam rec_t IDLE_REC = '{3'd0, 2'd0, 1'b0, 1'b0, 1'b0};

  rec_t        plan[$];
  rec_t        cur;
  logic        m_err;
  logic        m_abt;
  logic [15:0] m_sig;

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [1:0] o);
    logic [15:0] r;
    r = s << 1;
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {14'b0, o};
  endfunction

  task automatic build_plan(input logic [7:0] msk, input logic [7:0] dw);
    int d;
    d = (dw == 8'd0) ? 1 : int'(dw);
    plan.delete();
    for (int m = 0; m < 8; m++) begin
      if (msk[m]) begin
        for (int s = 0; s < SETTLE_CYC; s++)
          plan.push_back('{3'(m), 2'd0, 1'b0, 1'b1, 1'b0});
        for (int k = 0; k < d; k++)
          plan.push_back('{3'(m), 2'(k % 4), 1'b1, 1'b1, 1'b0});
      end
    end
    plan.push_back('{3'd0, 2'd0, 1'b0, 1'b1, 1'b1});
  endtask

  task automatic model_reset();
    plan.delete();
    cur   = IDLE_REC;
    m_err = 1'b0;
    m_abt = 1'b0;
    m_sig = 16'h0000;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    logic [15:0] es;
`ifdef TEST_SWEEP_MISR_EN
    es = m_sig;
`else
    es = 16'h0000;
`endif
    chk("sel1",    16'(outSel1),      16'(cur.sel1));
    chk("sel9",    16'(outSel9),      16'(cur.sel));
    chk("sel15",   16'(outSel15),     16'(cur.sel));
    chk("valid",   16'(outModeValid), 16'(cur.valid));
    chk("busy",    16'(outBusy),      16'(cur.busy));
    chk("done",    16'(outDone),      16'(cur.done));
    chk("aborted", 16'(outAborted),   16'(m_abt));
    chk("errnm",   16'(outErrNoMode), 16'(m_err));
    chk("sig",     outSignature,      es);
  endtask

  // One clock: drive inputs, advance the model, step the clock, compare.
  task automatic tick(input logic st, input logic ab, input logic [7:0] msk,
                      input logic [7:0] dw, input logic [1:0] ob);
    inStart    = st;
    inAbort    = ab;
    inModeMask = msk;
    inDwell    = dw;
    inObs      = ob;
    m_err = 1'b0;
    m_abt = 1'b0;
    if (!cur.busy) begin
      if (st) begin
        if (msk != 8'h00) begin
          build_plan(msk, dw);
          m_sig = 16'h0000;
        end else begin
          m_err = 1'b1;
        end
      end
    end else begin
      if (cur.valid) m_sig = misr(m_sig, ob);
      if (ab) begin
        plan.delete();
        m_abt = 1'b1;
      end
    end
    if (plan.size() > 0) cur = plan.pop_front();
    else                 cur = IDLE_REC;
    @(posedge inClock);
    #1;
    chk_model();
  endtask

  typedef struct {
    logic       st;
    logic       ab;
    logic [7:0] msk;
    logic [7:0] dw;
    logic [2:0] e_sel1;
    logic [1:0] e_sel;
    logic       e_valid;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic ab, input logic [7:0] msk,
                              input logic [7:0] dw, input logic [2:0] s1,
                              input logic [1:0] s, input logic v, input logic b,
                              input logic d, input logic e);
    vec_t r;
    r = '{st, ab, msk, dw, s1, s, v, b, d, e};
    return r;
  endfunction

  localparam int NV = 16;
  vec_t vt[NV];

  initial begin
    int          cnt;
    int          vcnt;
    logic        found;
    logic [2:0]  s1cap;
    logic [15:0] sigcap;

    // Mask 0x05, dwell 4: start sampled at the edge ending row 2's cycle.
    // Rows during the sweep also wiggle start/mask/dwell, which must be ignored.
    vt[0]  = mk(1, 0, 8'h00, 8'd4,  3'd0, 2'd0, 0, 0, 0, 1);
    vt[1]  = mk(0, 1, 8'h00, 8'd4,  3'd0, 2'd0, 0, 0, 0, 0);
    vt[2]  = mk(1, 1, 8'h05, 8'd4,  3'd0, 2'd0, 0, 1, 0, 0);
    vt[3]  = mk(0, 0, 8'hFF, 8'd1,  3'd0, 2'd0, 0, 1, 0, 0);
    vt[4]  = mk(0, 0, 8'h03, 8'd9,  3'd0, 2'd0, 1, 1, 0, 0);
    vt[5]  = mk(1, 0, 8'hFF, 8'd2,  3'd0, 2'd1, 1, 1, 0, 0);
    vt[6]  = mk(0, 0, 8'h00, 8'd0,  3'd0, 2'd2, 1, 1, 0, 0);
    vt[7]  = mk(0, 0, 8'h40, 8'd7,  3'd0, 2'd3, 1, 1, 0, 0);
    vt[8]  = mk(1, 0, 8'hFF, 8'd3,  3'd2, 2'd0, 0, 1, 0, 0);
    vt[9]  = mk(0, 0, 8'h05, 8'd4,  3'd2, 2'd0, 0, 1, 0, 0);
    vt[10] = mk(0, 0, 8'h05, 8'd4,  3'd2, 2'd0, 1, 1, 0, 0);
    vt[11] = mk(0, 0, 8'h05, 8'd4,  3'd2, 2'd1, 1, 1, 0, 0);
    vt[12] = mk(0, 0, 8'h05, 8'd4,  3'd2, 2'd2, 1, 1, 0, 0);
    vt[13] = mk(0, 0, 8'h05, 8'd4,  3'd2, 2'd3, 1, 1, 0, 0);
    vt[14] = mk(0, 0, 8'h05, 8'd4,  3'd0, 2'd0, 0, 1, 1, 0);
    vt[15] = mk(1, 0, 8'h05, 8'd4,  3'd0, 2'd0, 0, 0, 0, 0);

    inStart = 0; inAbort = 0; inModeMask = 0; inDwell = 0; inObs = 0;
    inReset = 1'b0;
    model_reset();
    @(posedge inClock); @(posedge inClock); #1;
    chk_model();
    inReset = 1'b1;

    // Directed vector table
    for (int k = 0; k < NV; k++) begin
      tick(vt[k].st, vt[k].ab, vt[k].msk, vt[k].dw, 2'b00);
      chk("tbl_sel1",  16'(outSel1),      16'(vt[k].e_sel1));
      chk("tbl_sel15", 16'(outSel15),     16'(vt[k].e_sel));
      chk("tbl_valid", 16'(outModeValid), 16'(vt[k].e_valid));
      chk("tbl_busy",  16'(outBusy),      16'(vt[k].e_busy));
      chk("tbl_done",  16'(outDone),      16'(vt[k].e_done));
      chk("tbl_err",   16'(outErrNoMode), 16'(vt[k].e_err));
    end

    // Mask 0x80, dwell 0: one measure cycle on mode 7
    tick(1, 0, 8'h80, 8'd0, 2'b01);
    vcnt = 0; s1cap = 3'd0; sigcap = 16'hFFFF;
    for (int i = 0; i < 20 && cur.busy; i++) begin
      tick(0, 0, 8'h00, 8'd0, 2'b01);
      if (outModeValid) begin vcnt++; s1cap = outSel1; end
      if (outDone) sigcap = outSignature;
    end
    chk("d0_valid_cnt", 16'(vcnt), 16'd1);
    chk("d0_sel1",      16'(s1cap), 16'd7);
    chk("d0_sig",       sigcap, EXP_SIG_D0);

    // Mask 0x01, dwell 2, constant observation 01
    tick(1, 0, 8'h01, 8'd2, 2'b01);
    sigcap = 16'hFFFF;
    for (int i = 0; i < 20 && cur.busy; i++) begin
      tick(0, 0, 8'h00, 8'd0, 2'b01);
      if (outDone) sigcap = outSignature;
    end
    chk("d2_sig", sigcap, EXP_SIG_D2);

    // Mask 0xFF, dwell 10, abort inside mode 3 measure window
    tick(1, 0, 8'hFF, 8'd10, 2'b10);
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      tick(0, 0, 8'hFF, 8'd10, 2'($urandom));
      if (cur.sel1 == 3'd3 && cur.valid) found = 1'b1;
    end
    chk("abort_reach", 16'(found), 16'd1);
    tick(0, 0, 8'hFF, 8'd10, 2'b11);
    tick(0, 1, 8'hFF, 8'd10, 2'b11);
    chk("abort_pulse", 16'(outAborted), 16'd1);
    chk("abort_busy",  16'(outBusy),    16'd0);
    chk("abort_sel1",  16'(outSel1),    16'd0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 8'hFF, 8'd10, 2'b00);
      if (outDone || outAborted) cnt++;
    end
    chk("abort_no_done", 16'(cnt), 16'd0);

    // Restart with a new mask after the abort
    tick(1, 0, 8'h12, 8'd3, 2'b01);
    cnt = 0;
    for (int i = 0; i < 60 && cur.busy; i++) begin
      tick(0, 0, 8'h00, 8'd0, 2'($urandom));
      if (outDone) cnt++;
    end
    chk("restart_done", 16'(cnt), 16'd1);

    // Asynchronous reset mid-sweep
    tick(1, 0, 8'h0F, 8'd3, 2'b01);
    for (int i = 0; i < 6; i++) tick(0, 0, 8'h00, 8'd0, 2'b11);
    #2;
    inReset = 1'b0;
    #1;
    model_reset();
    chk_model();
    @(posedge inClock); #1;
    inReset = 1'b1;
    chk_model();

    // Randomized stimulus
    for (int i = 0; i < 500; i++) begin
      logic       st, ab;
      logic [7:0] msk, dw;
      st  = ($urandom % 6) == 0;
      ab  = ($urandom % 50) == 0;
      msk = (($urandom % 6) == 0) ? 8'h00 : 8'($urandom);
      dw  = 8'($urandom % 6);
      tick(st, ab, msk, dw, 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
